// File: rtl/conv_psum_collector.sv
// rtl/conv_psum_collector.sv - conv row psum collector: warm-up discard, requantize, output FIFO
//
// Purpose
//   Consumes the saturated psum stream of one conv row. The first KERNEL_SIZE-1 samples
//   of every row are warm-up samples (the kernel window is not yet full), so they are dropped.
//   Every accepted sample is arithmetically shifted right by SHIFT, saturated to a signed
//   OUT_BW value and queued in a FIFO_DEPTH-entry FIFO behind a valid/ready output.
//   A one-cycle pulse marks the end of each IMG_W-sample row. A sticky flag records any
//   accepted sample that was lost because the FIFO was full.
//
// Configuration
//   CONV_COLLECT_RELU_EN : when defined, negative psums are clamped to 0 before the shift,
//                          so the output range becomes [0, 2**(OUT_BW-1)-1].
//
// Ports
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   i_valid      in   1       i_psum holds a valid sample
//   i_psum       in   SUM_BW  signed psum from the conv row
//   i_row_start  in   1       restart the column count (new row)
//   i_ready      in   1       consumer accepts o_data this cycle
//   o_valid      out  1       FIFO not empty
//   o_data       out  OUT_BW  FIFO head, signed requantized activation
//   o_row_done   out  1       one-cycle pulse after the last sample of a row
//   o_overflow   out  1       sticky: an accepted sample was dropped

module conv_psum_collector #(
   parameter int KERNEL_SIZE = 5,
   parameter int SUM_BW      = 16,
   parameter int OUT_BW      = 8,
   parameter int SHIFT       = 4,
   parameter int IMG_W       = 32,
   parameter int COL_BW      = 6,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic signed [SUM_BW-1:0] i_psum,
   input  logic                     i_row_start,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic signed [OUT_BW-1:0] o_data,
   output logic                     o_row_done,
   output logic                     o_overflow
);

   localparam int PTR_BW = $clog2(FIFO_DEPTH);
   localparam int CNT_BW = PTR_BW + 1;

   // Saturation thresholds expressed at psum width; ~SAT_HI equals -(2**(OUT_BW-1)).
   localparam logic signed [SUM_BW-1:0] SAT_HI = SUM_BW'(2 ** (OUT_BW - 1) - 1);
   localparam logic signed [SUM_BW-1:0] SAT_LO = ~SAT_HI;
   localparam logic signed [OUT_BW-1:0] OUT_MAX = {1'b0, {(OUT_BW - 1){1'b1}}};
   localparam logic signed [OUT_BW-1:0] OUT_MIN = {1'b1, {(OUT_BW - 1){1'b0}}};

   logic [COL_BW-1:0]        col;
   logic [COL_BW-1:0]        eff_col;
   logic                     last_col;
   logic                     accept;
   logic                     pop;
   logic                     push;
   logic                     drop;

   logic signed [SUM_BW-1:0] psum_in;
   logic signed [SUM_BW-1:0] shifted;
   logic signed [OUT_BW-1:0] wdata;

   logic signed [OUT_BW-1:0] mem [FIFO_DEPTH];
   logic [PTR_BW-1:0]        wr_ptr;
   logic [PTR_BW-1:0]        rd_ptr;
   logic [PTR_BW-1:0]        rd_ptr_nxt;
   logic [CNT_BW-1:0]        count;
   logic signed [OUT_BW-1:0] data_q;
   logic                     row_done_q;
   logic                     overflow_q;

   // Column tracking and accept decision. A row start in the same cycle as a sample makes
   // that sample column 0.
   always_comb begin
      eff_col  = i_row_start ? '0 : col;
      last_col = (eff_col == COL_BW'(IMG_W - 1));
      accept   = i_valid && (eff_col >= COL_BW'(KERNEL_SIZE - 1));
   end

   // Requantization. With ReLU enabled psum_in is never negative, so the lower saturation
   // branch can never fire and the effective lower bound is 0.
   always_comb begin
`ifdef CONV_COLLECT_RELU_EN
      psum_in = i_psum[SUM_BW-1] ? '0 : i_psum;
`else
      psum_in = i_psum;
`endif
      shifted = psum_in >>> SHIFT;
      if (shifted > SAT_HI) begin
         wdata = OUT_MAX;
      end else if (shifted < SAT_LO) begin
         wdata = OUT_MIN;
      end else begin
         wdata = shifted[OUT_BW-1:0];
      end
   end

   // A full FIFO still takes a sample when the head leaves in the same cycle.
   always_comb begin
      pop        = (count != '0) && i_ready;
      push       = accept && ((count != CNT_BW'(FIFO_DEPTH)) || pop);
      drop       = accept && !push;
      rd_ptr_nxt = rd_ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row_done_q <= 1'b0;
      end else begin
         row_done_q <= i_valid && last_col;
         if (i_valid) begin
            col <= last_col ? '0 : eff_col + 1'b1;
         end else if (i_row_start) begin
            col <= '0;
         end
      end
   end

   // Storage carries no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_nxt;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Registered head copy: it tracks the FIFO head while non-empty and keeps the last
   // value once the FIFO drains. The new head comes from the write data when the
   // FIFO is (or becomes) empty before this push, else from the next stored entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         if (push && ((count == '0) || (pop && (count == CNT_BW'(1))))) begin
            data_q <= wdata;
         end else if (pop && (count > CNT_BW'(1))) begin
            data_q <= mem[rd_ptr_nxt];
         end
      end
   end

   assign o_valid    = (count != '0);
   assign o_data     = data_q;
   assign o_row_done = row_done_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_conv_psum_collector.sv
// tb/tb_conv_psum_collector.sv - self-checking bench for conv_psum_collector
module tb_conv_psum_collector;

   localparam int K      = 3;
   localparam int SUM_BW = 16;
   localparam int OUT_BW = 8;
   localparam int SHIFT  = 2;
   localparam int IMG_W  = 8;
   localparam int COL_BW = 4;
   localparam int DEPTH  = 4;

   logic                     clk;
   logic                     rst_n;
   logic                     i_valid;
   logic signed [SUM_BW-1:0] i_psum;
   logic                     i_row_start;
   logic                     i_ready;
   logic                     o_valid;
   logic signed [OUT_BW-1:0] o_data;
   logic                     o_row_done;
   logic                     o_overflow;

   conv_psum_collector #(
      .KERNEL_SIZE(K),
      .SUM_BW     (SUM_BW),
      .OUT_BW     (OUT_BW),
      .SHIFT      (SHIFT),
      .IMG_W      (IMG_W),
      .COL_BW     (COL_BW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_psum     (i_psum),
      .i_row_start(i_row_start),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_row_done (o_row_done),
      .o_overflow (o_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int    n_checks;
   int    n_fail;
   string phase;

   // Reference model state: queue of pending outputs plus scalar flags.
   int mq[$];
   int mcol;
   int m_ovf;
   int m_data;
   int m_rd;
   int rd_pulses;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0d, expected %0d", phase, tag, obs, exp);
      end
   endtask

   // floor(p / 2**SHIFT), then clamp to the signed OUT_BW range.
   function automatic int requant(input int p);
      int d;
      int v;
      int hi;
      int lo;
      d  = 1 << SHIFT;
      hi = (1 << (OUT_BW - 1)) - 1;
      lo = -(1 << (OUT_BW - 1));
`ifdef CONV_COLLECT_RELU_EN
      if (p < 0) p = 0;
`endif
      if (p >= 0) v = p / d;
      else        v = -((-p + d - 1) / d);
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      mcol   = 0;
      m_ovf  = 0;
      m_data = 0;
      m_rd   = 0;
   endtask

   task automatic check_outputs();
      check_val("o_valid", int'(o_valid), int'(mq.size() != 0));
      check_val("o_data", int'(o_data), m_data);
      check_val("o_row_done", int'(o_row_done), m_rd);
      check_val("o_overflow", int'(o_overflow), m_ovf);
   endtask

   task automatic step(input bit v, input int p, input bit rs, input bit rdy);
      int eff;
      bit acc;
      bit popped;
      i_valid     = v;
      i_psum      = p[SUM_BW-1:0];
      i_row_start = rs;
      i_ready     = rdy;
      @(posedge clk);
      popped = (mq.size() > 0) && rdy;
      eff    = rs ? 0 : mcol;
      acc    = v && (eff >= K - 1);
      if (popped) void'(mq.pop_front());
      if (acc) begin
         if (mq.size() < DEPTH) mq.push_back(requant(p));
         else                   m_ovf = 1;
      end
      m_rd = (v && eff == IMG_W - 1) ? 1 : 0;
      if (v)       mcol = (eff == IMG_W - 1) ? 0 : eff + 1;
      else if (rs) mcol = 0;
      if (mq.size() > 0) m_data = mq[0];
      #1;
      if (o_row_done) rd_pulses++;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      i_valid     = 1'($urandom);
      i_psum      = SUM_BW'($urandom);
      i_row_start = 1'($urandom);
      i_ready     = 1'($urandom);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1);
   endtask

   int sat_vals[8] = '{0, 0, 1000, -1000, -5, 7, -32768, 32767};

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rd_pulses = 0;
      rst_n     = 1'b0;
      model_reset();

      phase = "reset";
      do_reset();

      phase = "ramp";
      for (int k = 0; k < 8; k++) step(1, 4 * k, 0, 1);
      idle(3);
      check_val("row_done_count", rd_pulses, 1);

      phase = "saturate";
      for (int k = 0; k < 8; k++) step(1, sat_vals[k], 0, 1);
      idle(3);

      phase = "overflow";
      do_reset();
      for (int k = 0; k < 8; k++) step(1, int'($urandom_range(0, 1200)) - 600, 0, 0);
      check_val("overflow_set", int'(o_overflow), 1);
      check_val("queue_full", int'(o_valid), 1);
      idle(6);

      phase = "full_pushpop";
      do_reset();
      for (int k = 0; k < 6; k++) step(1, 40 * k, 0, 0);
      step(1, 400, 0, 1);
      check_val("no_drop_ovf", int'(o_overflow), 0);
      step(1, 404, 0, 1);
      idle(6);

      phase = "row_restart";
      do_reset();
      for (int k = 0; k < 5; k++) step(1, 8 * k, 0, 1);
      step(1, 100, 1, 1);
      step(1, 104, 0, 1);
      step(1, 108, 0, 1);
      idle(3);

      phase = "midrow_reset";
      step(1, 12, 1, 0);
      step(1, 16, 0, 0);
      step(1, 20, 0, 0);
      step(1, 24, 0, 0);
      check_val("queued_before_reset", int'(o_valid), 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      phase = "random";
      for (int n = 0; n < 600; n++) begin
         logic [15:0] r;
         int          p;
         r = 16'($urandom);
         if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 1200)) - 600;
         else                           p = int'($signed(r));
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         step($urandom_range(0, 3) != 0, p, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
